// File: rtl/pad_cfg_ctrl.sv
// APB pad configuration registers (48 x 6-bit pad config bus, sticky LOCK)
// plus a boot-select sampler that latches the boot pads once they are stable after reset.
module pad_cfg_ctrl #(
    parameter int unsigned NB_PADS    = 48,
    parameter int unsigned RST_DLY    = 16,
    parameter int unsigned STABLE_CNT = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [11:0]               paddr_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic                      pwrite_i,
    input  logic [31:0]               pwdata_i,
    output logic [31:0]               prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    input  logic [1:0]                bootsel_i,
    output logic [NB_PADS-1:0][5:0]   pad_cfg_o,
    output logic [1:0]                bootsel_o,
    output logic                      bootsel_valid_o
);

    localparam int unsigned NB_WORDS = NB_PADS / 4;
    localparam int unsigned IDXW     = $clog2(NB_PADS);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_DONE   = 2'd2
    } boot_state_e;

    logic [NB_PADS-1:0][5:0] pad_q;
    logic                    lock_q;
    logic [1:0]              sync1_q, sync2_q;
    boot_state_e             state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [7:0]              run_q, run_d;
    logic [1:0]              ref_q, ref_d;
    logic [1:0]              bsel_q, bsel_d;
    logic                    valid_q, valid_d;

    logic [9:0]  word;
    logic        addr_pad, addr_status, addr_lock, addr_bad;
    logic        access, err, pad_wr, lock_wr;
    logic [31:0] rdata;
    logic        unused;

    function automatic logic [IDXW-1:0] pad_idx(input logic [9:0] w, input logic [1:0] j);
        return IDXW'({w, j});
    endfunction

    assign word        = paddr_i[11:2];
    assign addr_pad    = word < 10'(NB_WORDS);
    assign addr_status = word == 10'(NB_WORDS);
    assign addr_lock   = word == 10'(NB_WORDS + 1);
    assign addr_bad    = !(addr_pad || addr_status || addr_lock);

    assign access  = psel_i && penable_i;
    assign err     = access && (addr_bad || (pwrite_i && addr_status) ||
                                (pwrite_i && addr_pad && lock_q));
    assign pad_wr  = access && pwrite_i && addr_pad && !lock_q;
    assign lock_wr = access && pwrite_i && addr_lock && pwdata_i[0];

    always_comb begin
        rdata = '0;
        if (addr_pad) begin
            for (int unsigned j = 0; j < 4; j++) begin
                rdata[8*j +: 6] = pad_q[pad_idx(word, 2'(j))];
            end
        end else if (addr_status) begin
            rdata = {27'b0, state_q, valid_q, bsel_q};
        end else if (addr_lock) begin
            rdata = {31'b0, lock_q};
        end
    end

    assign prdata_o        = psel_i ? rdata : '0;
    assign pready_o        = 1'b1;
    assign pslverr_o       = err;
    assign pad_cfg_o       = pad_q;
    assign bootsel_o       = bsel_q;
    assign bootsel_valid_o = valid_q;
    assign unused          = ^{paddr_i[1:0], pwdata_i[7:6], pwdata_i[15:14],
                               pwdata_i[23:22], pwdata_i[31:30]};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pad_q  <= '0;
            lock_q <= 1'b0;
        end else begin
            if (lock_wr) begin
                lock_q <= 1'b1;
            end
            if (pad_wr) begin
                for (int unsigned j = 0; j < 4; j++) begin
                    pad_q[pad_idx(word, 2'(j))] <= pwdata_i[8*j +: 6];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= ST_WAIT;
            cnt_q   <= '0;
            run_q   <= '0;
            ref_q   <= '0;
            bsel_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            sync1_q <= bootsel_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            ref_q   <= ref_d;
            bsel_q  <= bsel_d;
            valid_q <= valid_d;
        end
    end

    // A mismatch against ref restarts the run from the new value rather than waiting for the old one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        ref_d   = ref_q;
        bsel_d  = bsel_q;
        valid_d = valid_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 8'(RST_DLY - 1)) begin
                    state_d = ST_SAMPLE;
                    run_d   = '0;
                    ref_d   = sync2_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SAMPLE: begin
                if (sync2_q == ref_q) begin
                    if (run_q == 8'(STABLE_CNT - 1)) begin
                        state_d = ST_DONE;
                        bsel_d  = ref_q;
                        valid_d = 1'b1;
                    end else begin
                        run_d = run_q + 8'd1;
                    end
                end else begin
                    ref_d = sync2_q;
                    run_d = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// Scoreboard bench for pad_cfg_ctrl: APB expectations queued by the driver, popped by a monitor;
// boot-select checked every cycle against a trace-window reference model.
module tb_pad_cfg_ctrl;

    localparam int unsigned RST_DLY    = 16;
    localparam int unsigned STABLE_CNT = 8;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic [11:0]       paddr = '0;
    logic              psel = 1'b0;
    logic              penable = 1'b0;
    logic              pwrite = 1'b0;
    logic [31:0]       pwdata = '0;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;
    logic [1:0]        bootsel = 2'b10;
    logic [47:0][5:0]  pad_cfg;
    logic [1:0]        bootsel_q;
    logic              bootsel_valid;

    int checks = 0;
    int errors = 0;

    pad_cfg_ctrl #(
        .NB_PADS    (48),
        .RST_DLY    (RST_DLY),
        .STABLE_CNT (STABLE_CNT)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .paddr_i         (paddr),
        .psel_i          (psel),
        .penable_i       (penable),
        .pwrite_i        (pwrite),
        .pwdata_i        (pwdata),
        .prdata_o        (prdata),
        .pready_o        (pready),
        .pslverr_o       (pslverr),
        .bootsel_i       (bootsel),
        .pad_cfg_o       (pad_cfg),
        .bootsel_o       (bootsel_q),
        .bootsel_valid_o (bootsel_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0]      addr;
        bit               is_write;
        bit               is_status;
        logic [31:0]      rdata;
        bit               err;
        logic [47:0][5:0] pad;
    } exp_t;

    exp_t exp_q[$];

    // Register-level model
    logic [47:0][5:0] pad_m = '0;
    bit               lock_m = 1'b0;

    // Boot-select model: input trace since reset release
    logic [1:0] in_hist[$];
    int         n_edges = 0;
    bit         done_m = 1'b0;
    logic [1:0] bsel_m = 2'b00;
    bit         model_init = 1'b0;

    // Value seen by the sampler at edge k: the raw input two edges earlier, 0 before that.
    function automatic logic [1:0] s_at(input int k);
        if (k >= 3) return in_hist[k-3];
        return 2'b00;
    endfunction

    function automatic logic [31:0] status_model();
        logic [1:0] st;
        st = done_m ? 2'd2 : ((n_edges >= int'(RST_DLY)) ? 2'd1 : 2'd0);
        return {27'b0, st, done_m, bsel_m};
    endfunction

    // Valid after the first edge n past the wait window whose last STABLE_CNT+1 samples all agree.
    initial forever begin
        @(posedge clk);
        if (!rst_ni) begin
            model_init = 1'b1;
            n_edges = 0;
            in_hist.delete();
            done_m = 1'b0;
            bsel_m = 2'b00;
        end else begin
            bit all_eq;
            n_edges++;
            in_hist.push_back(bootsel);
            if (!done_m && n_edges >= int'(RST_DLY + STABLE_CNT)) begin
                all_eq = 1'b1;
                for (int k = n_edges - int'(STABLE_CNT); k <= n_edges; k++) begin
                    if (s_at(k) != s_at(n_edges)) all_eq = 1'b0;
                end
                if (all_eq) begin
                    done_m = 1'b1;
                    bsel_m = s_at(n_edges);
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (model_init) begin
            checks++;
            if (bootsel_valid !== done_m) begin
                errors++;
                $display("FAIL bootsel_valid t=%0t edge=%0d got=%b exp=%b", $time, n_edges, bootsel_valid, done_m);
            end
            checks++;
            if (bootsel_q !== bsel_m) begin
                errors++;
                $display("FAIL bootsel t=%0t edge=%0d got=%b exp=%b", $time, n_edges, bootsel_q, bsel_m);
            end
            checks++;
            if (pready !== 1'b1) begin
                errors++;
                $display("FAIL pready t=%0t got=%b exp=1", $time, pready);
            end
        end
    end

    initial forever begin
        exp_t        e;
        logic [31:0] exp_rd;
        @(negedge clk);
        if (psel && penable) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL apb_unexpected addr=%h got=access exp=none", paddr);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (pslverr !== e.err) begin
                    errors++;
                    $display("FAIL pslverr addr=%h wr=%b got=%b exp=%b", e.addr, e.is_write, pslverr, e.err);
                end
                if (!e.is_write) begin
                    exp_rd = e.is_status ? status_model() : e.rdata;
                    checks++;
                    if (prdata !== exp_rd) begin
                        errors++;
                        $display("FAIL prdata addr=%h got=%h exp=%h", e.addr, prdata, exp_rd);
                    end
                end
                @(posedge clk);
                #2;
                checks++;
                if (pad_cfg !== e.pad) begin
                    errors++;
                    $display("FAIL pad_cfg addr=%h got=%h exp=%h", e.addr, pad_cfg, e.pad);
                end
            end
        end
    end

    task automatic apb(input logic [11:0] a, input bit w, input logic [31:0] d, input bit in_rst);
        exp_t        e;
        int unsigned wd;
        wd          = int'(a[11:2]);
        e.addr      = a;
        e.is_write  = w;
        e.is_status = 1'b0;
        e.rdata     = '0;
        e.err       = 1'b0;
        if (a >= 12'h038) begin
            e.err = 1'b1;
        end else if (wd == 12) begin
            if (w) e.err = 1'b1;
            else   e.is_status = 1'b1;
        end else if (wd == 13) begin
            if (w) begin
                if (!in_rst && d[0]) lock_m = 1'b1;
            end else begin
                e.rdata = {31'b0, lock_m};
            end
        end else begin
            if (w) begin
                if (lock_m) e.err = 1'b1;
                else if (!in_rst) begin
                    for (int j = 0; j < 4; j++) pad_m[wd*4 + j] = d[8*j +: 6];
                end
            end else begin
                for (int j = 0; j < 4; j++) e.rdata[8*j +: 8] = {2'b00, pad_m[wd*4 + j]};
            end
        end
        e.pad = pad_m;
        @(posedge clk);
        #1;
        paddr   = a;
        pwrite  = w;
        pwdata  = d;
        psel    = 1'b1;
        penable = 1'b0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(posedge clk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    // Reset for several cycles with a pad write issued while reset is held; it must not land.
    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        pad_m  = '0;
        lock_m = 1'b0;
        @(posedge clk);
        apb(12'h004, 1'b1, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bootsel = 2'b10;
        do_reset();
        apb(12'h034, 1'b0, '0, 1'b0);
        apb(12'h030, 1'b0, '0, 1'b0);
        apb(12'h000, 1'b0, '0, 1'b0);

        apb(12'h02C, 1'b1, 32'h3F2A_1501, 1'b0);
        apb(12'h02C, 1'b0, '0, 1'b0);
        apb(12'h000, 1'b1, 32'hFFFF_FFFF, 1'b0);
        apb(12'h000, 1'b0, '0, 1'b0);

        repeat (20) @(negedge clk);
        apb(12'h030, 1'b0, '0, 1'b0);
        @(negedge clk);
        bootsel = 2'b01;
        repeat (6) @(negedge clk);

        apb(12'h040, 1'b0, '0, 1'b0);
        apb(12'hFFC, 1'b1, 32'h1234_5678, 1'b0);
        apb(12'h030, 1'b1, 32'hFFFF_FFFF, 1'b0);
        apb(12'h030, 1'b0, '0, 1'b0);

        apb(12'h034, 1'b1, 32'h0000_0001, 1'b0);
        apb(12'h000, 1'b1, 32'h0101_0101, 1'b0);
        apb(12'h000, 1'b0, '0, 1'b0);
        apb(12'h034, 1'b1, 32'h0000_0000, 1'b0);
        apb(12'h034, 1'b0, '0, 1'b0);

        // Glitch once the sampler has accumulated part of a run
        bootsel = 2'b10;
        do_reset();
        repeat (RST_DLY + 5) @(negedge clk);
        bootsel = 2'b01;
        @(negedge clk);
        bootsel = 2'b10;
        repeat (30) @(negedge clk);
        apb(12'h030, 1'b0, '0, 1'b0);

        bootsel = 2'b11;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            logic [11:0] a;
            bit          w;
            @(negedge clk);
            bootsel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = 12'($urandom_range(0, 4095));
            else                           a = 12'($urandom_range(0, 15) * 4);
            w = 1'($urandom_range(0, 1));
            apb(a, w, $urandom, 1'b0);
        end
        bootsel = 2'b01;
        repeat (RST_DLY + STABLE_CNT + 6) @(negedge clk);
        apb(12'h030, 1'b0, '0, 1'b0);
        for (int i = 0; i < 12; i++) apb(12'(i * 4), 1'b0, '0, 1'b0);

        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL apb_drain got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
